// File: rtl/stall_dmem_responder_pkg.sv
// Shared types for the stalling data-memory responder: FSM state and operation encodings.
package stall_dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int CNT_W = 4;

  // A request is rejected when both ops are set or the byte address is odd.
  function automatic logic req_bad(input logic rd, input logic wr, input logic addr_lsb);
    return (rd & wr) | addr_lsb;
  endfunction

endpackage

// File: rtl/stall_dmem_responder_if.sv
// Request/response bundle between the Memory stage and the stalling data memory.
interface stall_dmem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req_rd, req_wr, req_addr, req_wdata,
    input  stall, done, rdata, err
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata,
    output stall, done, rdata, err
  );
endinterface

// File: rtl/stall_dmem_responder_dmem_array.sv
// Single-port synchronous word RAM; dout is registered and only changes on reads.
module dmem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wr,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) mem[addr] <= din;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/stall_dmem_responder.sv
// Multi-cycle data memory: accepts one request, stalls the requester for LATENCY
// cycles, then pulses done with read data or an error flag.
module stall_dmem_responder
  import stall_dmem_responder_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stall_dmem_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  op_t                     op_q;
  logic                    bad_q;
  logic [DEPTH_LOG2-1:0]   word_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       rdata_hold;
  logic [DATA_W-1:0]       ram_dout;

  logic                    req, in_idle, accept, access, rd_hit;
  op_t                     acc_op;
  logic                    acc_bad;
  logic [DEPTH_LOG2-1:0]   acc_word;
  logic [DATA_W-1:0]       acc_wdata;
  logic                    unused_addr_hi;

  assign req            = bus.req_rd | bus.req_wr;
  assign in_idle        = (state == ST_IDLE);
  assign accept         = in_idle & req;
  assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:DEPTH_LOG2+1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // With LATENCY==1 the access edge is the acceptance edge, so use live inputs there.
  assign acc_op    = in_idle ? (bus.req_wr ? OP_WR : OP_RD) : op_q;
  assign acc_bad   = in_idle ? req_bad(bus.req_rd, bus.req_wr, bus.req_addr[0]) : bad_q;
  assign acc_word  = in_idle ? bus.req_addr[DEPTH_LOG2:1] : word_q;
  assign acc_wdata = in_idle ? bus.req_wdata : wdata_q;
  assign access    = (state_nxt == ST_RESP) && (state != ST_RESP) && !acc_bad;

  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (access),
    .wr   (acc_op == OP_WR),
    .addr (acc_word),
    .din  (acc_wdata),
    .dout (ram_dout)
  );

  assign bus.done  = (state == ST_RESP);
  assign bus.err   = bus.done & bad_q;
  assign bus.stall = in_idle ? req : (state == ST_WAIT);
  assign rd_hit    = bus.done & !bad_q & (op_q == OP_RD);
  assign bus.rdata = rd_hit ? ram_dout : rdata_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_q       <= OP_RD;
      bad_q      <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      rdata_hold <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= CNT_LOAD;
        op_q    <= bus.req_wr ? OP_WR : OP_RD;
        bad_q   <= req_bad(bus.req_rd, bus.req_wr, bus.req_addr[0]);
        word_q  <= bus.req_addr[DEPTH_LOG2:1];
        wdata_q <= bus.req_wdata;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (rd_hit) rdata_hold <= ram_dout;
    end
  end

endmodule

// File: tb/tb_stall_dmem_responder.sv
// Bench for stall_dmem_responder: three instances (LATENCY 2, 1, 15) driven by directed steps.
module tb_stall_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_rd_s    [3];
  logic        req_wr_s    [3];
  logic [15:0] req_addr_s  [3];
  logic [15:0] req_wdata_s [3];
  logic        stall_s     [3];
  logic        done_s      [3];
  logic        err_s       [3];
  logic [15:0] rdata_s     [3];

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] mem_m [int];
  logic [15:0] last_rd [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    stall_dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus ();
    assign bus.req_rd    = req_rd_s[g];
    assign bus.req_wr    = req_wr_s[g];
    assign bus.req_addr  = req_addr_s[g];
    assign bus.req_wdata = req_wdata_s[g];
    assign stall_s[g]    = bus.stall;
    assign done_s[g]     = bus.done;
    assign err_s[g]      = bus.err;
    assign rdata_s[g]    = bus.rdata;
    stall_dmem_responder #(
      .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(LAT)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 15;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input int d, input logic rd, input logic wr,
                            input logic [15:0] addr, input logic [15:0] wdata);
    logic bad;
    int   key;
    exp_t e;
    bad = (rd & wr) | addr[0];
    key = d * 4096 + int'(addr[10:1]);
    if (!bad && wr) mem_m[key] = wdata;
    if (!bad && rd) last_rd[d] = mem_m.exists(key) ? mem_m[key] : 16'hxxxx;
    e.rdata = last_rd[d];
    e.err   = bad;
    sb.push_back(e);
  endtask

  // Entered just after a rising edge; leaves the request dropped one cycle after done.
  task automatic do_req(input int d, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [15:0] wdata, input bit scramble);
    int   lat;
    exp_t e;
    lat            = lat_of(d);
    req_rd_s[d]    = rd;
    req_wr_s[d]    = wr;
    req_addr_s[d]  = addr;
    req_wdata_s[d] = wdata;
    model_push(d, rd, wr, addr, wdata);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        check("stall_busy", 32'(stall_s[d]), 32'd1);
        check("done_early", 32'(done_s[d]), 32'd0);
        check("err_nodone", 32'(err_s[d]), 32'd0);
      end else begin
        check("stall_resp", 32'(stall_s[d]), 32'd0);
        check("done", 32'(done_s[d]), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rdata", 32'(rdata_s[d]), 32'(e.rdata));
          check("err", 32'(err_s[d]), 32'(e.err));
        end
      end
      @(posedge clk);
      #1;
      if (scramble && c < lat) begin
        req_addr_s[d]  = 16'($urandom);
        req_wdata_s[d] = 16'($urandom);
      end
    end
    req_rd_s[d] = 1'b0;
    req_wr_s[d] = 1'b0;
  endtask

  logic [15:0] r_addr [4];
  logic [15:0] r_data [4];
  exp_t        e_b2b;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req_rd_s[d]    = 1'b0;
      req_wr_s[d]    = 1'b0;
      req_addr_s[d]  = '0;
      req_wdata_s[d] = '0;
      last_rd[d]     = '0;
    end

    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_stall", 32'(stall_s[d]), 32'd0);
      check("rst_done", 32'(done_s[d]), 32'd0);
      check("rst_err", 32'(err_s[d]), 32'd0);
      check("rst_rdata", 32'(rdata_s[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write then read at LATENCY=2
    do_req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

    // LATENCY=1, continuous reads: accept, done, accept, done ...
    do_req(1, 1'b0, 1'b1, 16'h0040, 16'h1357, 1'b0);
    req_rd_s[1]   = 1'b1;
    req_addr_s[1] = 16'h0040;
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) model_push(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
      @(negedge clk);
      check("b2b_stall", 32'(stall_s[1]), (c % 2 == 0) ? 32'd1 : 32'd0);
      check("b2b_done", 32'(done_s[1]), (c % 2 == 1) ? 32'd1 : 32'd0);
      if (c % 2 == 1 && sb.size() > 0) begin
        e_b2b = sb.pop_front();
        check("b2b_rdata", 32'(rdata_s[1]), 32'(e_b2b.rdata));
      end
      @(posedge clk);
      #1;
    end
    req_rd_s[1] = 1'b0;
    @(negedge clk);
    check("b2b_idle_done", 32'(done_s[1]), 32'd0);
    @(posedge clk);
    #1;

    // Rejected requests keep rdata and leave the array untouched
    do_req(0, 1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0);
    do_req(0, 1'b0, 1'b1, 16'h0011, 16'hDEAD, 1'b0);
    do_req(0, 1'b1, 1'b1, 16'h0010, 16'h0BAD, 1'b0);
    do_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);

    // Address wrap and top address
    do_req(0, 1'b0, 1'b1, 16'h0802, 16'h1234, 1'b0);
    do_req(0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
    do_req(0, 1'b0, 1'b1, 16'hFFFE, 16'h7777, 1'b0);
    do_req(0, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 1'b0);

    // Reset during WAIT discards the pending write
    do_req(0, 1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0);
    req_wr_s[0]    = 1'b1;
    req_addr_s[0]  = 16'h0020;
    req_wdata_s[0] = 16'hAAAA;
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    req_wr_s[0] = 1'b0;
    for (int d = 0; d < 3; d++) last_rd[d] = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("mid_rst_done", 32'(done_s[0]), 32'd0);
      check("mid_rst_err", 32'(err_s[0]), 32'd0);
      check("mid_rst_stall", 32'(stall_s[0]), 32'd0);
      check("mid_rst_rdata", 32'(rdata_s[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", 32'(done_s[0]), 32'd0);
    @(posedge clk);
    #1;
    do_req(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

    // LATENCY=15 with request inputs scrambled after acceptance
    for (int i = 0; i < 4; i++) begin
      r_addr[i] = 16'($urandom_range(0, 32767) * 2);
      r_data[i] = 16'($urandom);
      do_req(2, 1'b0, 1'b1, r_addr[i], r_data[i], 1'b1);
    end
    for (int i = 0; i < 4; i++) do_req(2, 1'b1, 1'b0, r_addr[i], 16'h0000, 1'b1);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
